renkon_layer_seq: RTL and testbench
===================================

RENKON_LAYER_SEQ -- requirements
Module: renkon_layer_seq

Interface
REQ-001 Parameter: LAYER_MAX, default 16, is the descriptor-table depth (power of two).
REQ-002 Parameter: ACK_TIMEOUT, default 4, is the maximum number of cycles after req within which ack must fall.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clk  in  1  clock.
REQ-005 xrst  in  1  synchronous active-low reset.
REQ-006 desc_we  in  1  host descriptor write strobe.
REQ-007 desc_addr  in  $clog2(LAYER_MAX)  descriptor index.
REQ-008 desc_wdata  in  layer_desc_t  descriptor fields: in_offset[IMGSIZE], out_offset[IMGSIZE], net_offset[RENKON_NETSIZE], total_out, total_in, img_size, fil_size[LWIDTH each].
REQ-009 run  in  1  host pulse that starts a sequence.
REQ-010 layer_count  in  $clog2(LAYER_MAX)+1  number of layers to execute; sampled on run.
REQ-011 halt  in  1  host pulse requesting a stop after the current layer.
REQ-012 ack  in  1  core ready/complete flag: high when idle, falls after req, rises when the layer finishes.
REQ-013 req  out  1  single-cycle layer request to the core.
REQ-014 in_offset, out_offset, net_offset, total_out, total_in, img_size, fil_size  out  per field width  layer parameters presented to the core.
REQ-015 busy  out  1  sequence in progress.
REQ-016 done  out  1  single-cycle pulse when the sequence ends.
REQ-017 err  out  1  sticky handshake error flag.
REQ-018 cur_layer  out  $clog2(LAYER_MAX)  index of the layer being issued or executed.

Function
REQ-019 Storage: descriptor table of LAYER_MAX entries; a write takes effect on the edge where desc_we=1, and only when busy=0 (writes while busy are dropped).
REQ-020 FSM states: S_IDLE, S_LOAD, S_ISSUE, S_WAIT_LOW, S_WAIT_HIGH, S_NEXT.
REQ-021 S_IDLE: on run with layer_count>0 and ack=1, latch layer_count, clear cur_layer to 0, set busy=1 and go to S_LOAD.
REQ-022 S_IDLE, run with layer_count=0: pulse done one cycle later, emit no req, keep busy=0.
REQ-023 S_IDLE, run while ack=0: ignore run.
REQ-024 S_LOAD: register table[cur_layer] onto the parameter outputs and go to S_ISSUE.
REQ-025 S_ISSUE: req=1 for exactly this cycle; go to S_WAIT_LOW and clear the timeout counter.
REQ-026 Parameter outputs: change only in S_LOAD and stay stable through S_WAIT_HIGH and after done, because the core latches offsets on req or ack.
REQ-027 S_WAIT_LOW, ack=0: go to S_WAIT_HIGH.
REQ-028 S_WAIT_LOW, ack=1: increment the timeout counter; when the counter reaches ACK_TIMEOUT, set err=1, pulse done, clear busy and go to S_IDLE.
REQ-029 S_WAIT_HIGH, ack=1: go to S_NEXT.
REQ-030 S_NEXT, cur_layer+1 == latched count, or a halt is pending: pulse done, clear busy and the halt flag, go to S_IDLE.
REQ-031 S_NEXT, otherwise: increment cur_layer and go to S_LOAD.
REQ-032 Back-to-back layers: minimum 3 cycles from ack rising to the next req.
REQ-033 halt: recorded in a pending flag in any busy state and never aborts a layer in flight; halt in S_IDLE is ignored.
REQ-034 Simultaneous halt and the S_NEXT evaluation: the halt is honoured in that cycle.
REQ-035 err: cleared only by the next accepted run or by reset.
REQ-036 run while busy=1: ignored.

Reset
REQ-037 Reset values: req=0, busy=0, done=0, err=0, cur_layer=0, all parameter outputs 0, FSM=S_IDLE, halt pending=0, timeout counter=0; table contents undefined.
REQ-038 Reset asserted mid-layer returns the block to S_IDLE on the next edge; no req is issued while xrst=0.

Structure
REQ-039 layer_desc_t (packed struct) and the state enum belong in the shared renkon package/header alongside IMGSIZE, LWIDTH and RENKON_NETSIZE.
REQ-040 The descriptor table is one sub-module, renkon_desc_ram: one write port and one registered read port, read in S_LOAD.

Verification
REQ-041 Load 3 descriptors (img_size 12/10/8), run with layer_count=3, model ack fall 1 cycle after req and rise 50 cycles later -> exactly 3 req pulses, parameters match each descriptor at req, done after the 3rd ack rises, busy=0.
REQ-042 run with layer_count=0 -> done 1 cycle later, no req, busy stays 0.
REQ-043 layer_count=4, halt during layer 1 -> layers 0 and 1 complete, no 3rd req, done pulse, cur_layer=1.
REQ-044 ack held at 1 after req, ACK_TIMEOUT=4 -> err=1 and done 4 cycles after entering S_WAIT_LOW; the next run clears err.
REQ-045 desc_we to index 0 while busy -> table unchanged, verified on a rerun; reset asserted mid-layer -> all outputs at reset values, no spurious req.

Source files
------------

// File: rtl/renkon_pkg.sv
// Renkon shared types: layer descriptor, sequencer states
// and the field widths the core expects.
package renkon_pkg;

    localparam int IMGSIZE        = 16;
    localparam int LWIDTH         = 8;
    localparam int RENKON_NETSIZE = 12;

    typedef struct packed {
        logic [IMGSIZE-1:0]        in_offset;
        logic [IMGSIZE-1:0]        out_offset;
        logic [RENKON_NETSIZE-1:0] net_offset;
        logic [LWIDTH-1:0]         total_out;
        logic [LWIDTH-1:0]         total_in;
        logic [LWIDTH-1:0]         img_size;
        logic [LWIDTH-1:0]         fil_size;
    } layer_desc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_NEXT
    } seq_state_t;

endpackage

// File: rtl/renkon_desc_ram.sv
// Descriptor table: one write port, one registered read port.
// The read register doubles as the parameter holding register.
module renkon_desc_ram
    import renkon_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          xrst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  layer_desc_t   i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output layer_desc_t   o_rdata
);

    layer_desc_t r_mem [DEPTH];
    layer_desc_t r_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            r_q <= '0;
        end else if (i_re) begin
            r_q <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/renkon_layer_seq.sv
// Layer sequencer: walks the descriptor table and hands one
// layer at a time to the core over the req/ack handshake.
module renkon_layer_seq
    import renkon_pkg::*;
#(
    parameter int LAYER_MAX   = 16,
    parameter int ACK_TIMEOUT = 4,
    localparam int AW = $clog2(LAYER_MAX),
    localparam int CW = AW + 1,
    localparam int TW = $clog2(ACK_TIMEOUT + 1)
) (
    input  logic                      clk,
    input  logic                      xrst,
    input  logic                      desc_we,
    input  logic [AW-1:0]             desc_addr,
    input  layer_desc_t               desc_wdata,
    input  logic                      run,
    input  logic [CW-1:0]             layer_count,
    input  logic                      halt,
    input  logic                      ack,
    output logic                      req,
    output logic [IMGSIZE-1:0]        in_offset,
    output logic [IMGSIZE-1:0]        out_offset,
    output logic [RENKON_NETSIZE-1:0] net_offset,
    output logic [LWIDTH-1:0]         total_out,
    output logic [LWIDTH-1:0]         total_in,
    output logic [LWIDTH-1:0]         img_size,
    output logic [LWIDTH-1:0]         fil_size,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [AW-1:0]             cur_layer
);

    seq_state_t    r_state;
    seq_state_t    w_next;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_cur;
    logic [TW-1:0] r_tmo;
    logic          r_halt;
    logic          r_err;
    logic          r_done;
    logic          w_start;
    logic          w_zero;
    logic          w_last;
    logic          w_stop;
    logic          w_tmo_hit;
    logic          w_rd_en;
    layer_desc_t   w_rdata;

    assign w_start   = run && ack && (layer_count != '0);
    assign w_zero    = run && ack && (layer_count == '0);
    assign w_last    = (({1'b0, r_cur} + CW'(1)) == r_count);
    assign w_stop    = w_last || r_halt || halt;
    assign w_tmo_hit = ack && (r_tmo == TW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!xrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:      if (w_start) w_next = S_LOAD;
            S_LOAD:      w_next = S_ISSUE;
            S_ISSUE:     w_next = S_WAIT_LOW;
            S_WAIT_LOW: begin
                if (!ack) begin
                    w_next = S_WAIT_HIGH;
                end else if (w_tmo_hit) begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT_HIGH: if (ack) w_next = S_NEXT;
            S_NEXT:      w_next = w_stop ? S_IDLE : S_LOAD;
            default:     w_next = S_IDLE;
        endcase
    end

    // req is gated by reset so a reset landing on S_ISSUE never leaks a pulse
    always_comb begin
        req     = 1'b0;
        busy    = 1'b1;
        w_rd_en = 1'b0;
        unique case (r_state)
            S_IDLE:  busy = 1'b0;
            S_LOAD:  w_rd_en = 1'b1;
            S_ISSUE: req = xrst;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            r_count <= '0;
            r_cur   <= '0;
            r_tmo   <= '0;
            r_halt  <= 1'b0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (halt && r_state != S_IDLE && r_state != S_NEXT) begin
                r_halt <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_count <= layer_count;
                        r_cur   <= '0;
                        r_err   <= 1'b0;
                        r_halt  <= 1'b0;
                    end
                    r_done <= w_zero;
                end
                S_ISSUE: r_tmo <= '0;
                S_WAIT_LOW: begin
                    if (w_tmo_hit) begin
                        r_err  <= 1'b1;
                        r_done <= 1'b1;
                    end else if (ack) begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_NEXT: begin
                    if (w_stop) begin
                        r_done <= 1'b1;
                        r_halt <= 1'b0;
                    end else begin
                        r_cur <= r_cur + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    renkon_desc_ram #(
        .DEPTH (LAYER_MAX)
    ) u_ram (
        .clk     (clk),
        .xrst    (xrst),
        .i_we    (desc_we && !busy),
        .i_waddr (desc_addr),
        .i_wdata (desc_wdata),
        .i_re    (w_rd_en),
        .i_raddr (r_cur),
        .o_rdata (w_rdata)
    );

    assign in_offset  = w_rdata.in_offset;
    assign out_offset = w_rdata.out_offset;
    assign net_offset = w_rdata.net_offset;
    assign total_out  = w_rdata.total_out;
    assign total_in   = w_rdata.total_in;
    assign img_size   = w_rdata.img_size;
    assign fil_size   = w_rdata.fil_size;
    assign err        = r_err;
    assign done       = r_done;
    assign cur_layer  = r_cur;

endmodule

// File: tb/tb_renkon_layer_seq.sv
// Bench for renkon_layer_seq: per-run expected timelines built
// from the handshake rules, compared every cycle.
module tb_renkon_layer_seq;
    import renkon_pkg::*;

    localparam int LM   = 16;
    localparam int TMO  = 4;
    localparam int AW   = $clog2(LM);
    localparam int CW   = AW + 1;
    localparam int MAXW = 256;

    logic clk = 1'b0;
    logic xrst = 1'b0;
    logic desc_we = 1'b0;
    logic [AW-1:0] desc_addr = '0;
    layer_desc_t desc_wdata = '0;
    logic run = 1'b0;
    logic [CW-1:0] layer_count = '0;
    logic halt = 1'b0;
    logic ack = 1'b1;
    logic req, busy, done, err;
    logic [IMGSIZE-1:0] in_offset, out_offset;
    logic [RENKON_NETSIZE-1:0] net_offset;
    logic [LWIDTH-1:0] total_out, total_in, img_size, fil_size;
    logic [AW-1:0] cur_layer;
    layer_desc_t got;

    renkon_layer_seq #(.LAYER_MAX(LM), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .xrst(xrst), .desc_we(desc_we),
        .desc_addr(desc_addr), .desc_wdata(desc_wdata),
        .run(run), .layer_count(layer_count), .halt(halt),
        .ack(ack), .req(req), .in_offset(in_offset),
        .out_offset(out_offset), .net_offset(net_offset),
        .total_out(total_out), .total_in(total_in),
        .img_size(img_size), .fil_size(fil_size), .busy(busy),
        .done(done), .err(err), .cur_layer(cur_layer)
    );

    assign got = {in_offset, out_offset, net_offset, total_out,
                  total_in, img_size, fil_size};

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    int n_req = 0;
    int wc = 0;
    bit chk_on = 1'b0;

    layer_desc_t shadow [8];
    layer_desc_t m_par = '0;
    logic [AW-1:0] m_cur = '0;
    logic m_err = 1'b0;

    logic ack_w [MAXW];
    logic run_w [MAXW];
    logic halt_w [MAXW];
    logic we_w [MAXW];
    logic [CW-1:0] lc_w [MAXW];
    layer_desc_t we_dat;
    logic e_req [MAXW];
    logic e_busy [MAXW];
    logic e_done [MAXW];
    logic e_err [MAXW];
    logic [AW-1:0] e_cur [MAXW];
    layer_desc_t e_par [MAXW];
    int f_a [8];
    int h_a [8];

    task automatic chk(input string nm, input logic [127:0] a,
                       input logic [127:0] e);
        n_vec++;
        if (a !== e) begin
            n_mis++;
            $display("FAIL %s t=%0t cyc=%0d got=%0h exp=%0h",
                     nm, $time, wc, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (req === 1'b1) n_req++;
        if (chk_on) begin
            chk("req", 128'(req), 128'(e_req[wc]));
            chk("busy", 128'(busy), 128'(e_busy[wc]));
            chk("done", 128'(done), 128'(e_done[wc]));
            chk("err", 128'(err), 128'(e_err[wc]));
            chk("cur_layer", 128'(cur_layer), 128'(e_cur[wc]));
            chk("params", 128'(got), 128'(e_par[wc]));
        end
    end

    function automatic layer_desc_t rnd_desc();
        layer_desc_t d;
        logic [31:0] x;
        logic [31:0] y;
        x = $urandom();
        y = $urandom();
        d.in_offset  = x[15:0];
        d.out_offset = x[31:16];
        d.net_offset = y[11:0];
        d.total_out  = y[19:12];
        d.total_in   = y[27:20];
        x = $urandom();
        d.img_size   = x[7:0];
        d.fil_size   = x[15:8];
        return d;
    endfunction

    task automatic wr_desc(input int a, input layer_desc_t d);
        @(posedge clk); #1;
        desc_we = 1'b1;
        desc_addr = AW'(a);
        desc_wdata = d;
        @(posedge clk); #1;
        desc_we = 1'b0;
        shadow[a] = d;
    endtask

    // Expected timeline of one run window; run is applied at cycle 0.
    task automatic build(input int n, input int hc, input bit r2,
                         input bit wr, input bit ign, output int len);
        int r, hh, endc, x;
        bit tmo;
        logic [31:0] rv;
        for (int c = 0; c < MAXW; c++) begin
            ack_w[c] = 1'b1; run_w[c] = 1'b0; halt_w[c] = 1'b0;
            we_w[c] = 1'b0; lc_w[c] = '0; e_req[c] = 1'b0;
            e_busy[c] = 1'b0; e_done[c] = 1'b0; e_err[c] = m_err;
            e_cur[c] = m_cur; e_par[c] = m_par;
        end
        run_w[0] = 1'b1;
        lc_w[0] = CW'(n);
        if (ign) begin
            ack_w[0] = 1'b0;
            len = 4;
            return;
        end
        if (n == 0) begin
            e_done[1] = 1'b1;
            len = 4;
            return;
        end
        r = 2; endc = 0; tmo = 1'b0;
        for (int i = 0; i < n; i++) begin
            e_req[r] = 1'b1;
            for (int c = r - 1; c < MAXW; c++) e_cur[c] = AW'(i);
            for (int c = r; c < MAXW; c++) e_par[c] = shadow[i];
            if (f_a[i] > TMO) begin
                tmo = 1'b1;
                endc = r + TMO + 1;
                break;
            end
            for (int c = r + f_a[i]; c < r + f_a[i] + h_a[i]; c++)
                ack_w[c] = 1'b0;
            hh = r + f_a[i] + h_a[i];
            if (i == n - 1 || (hc >= 1 && hc <= hh + 1)) begin
                endc = hh + 2;
                break;
            end
            r = hh + 3;
        end
        for (int c = 1; c < MAXW; c++) begin
            e_busy[c] = (c < endc);
            e_err[c] = tmo && (c >= endc);
        end
        e_done[endc] = 1'b1;
        if (hc >= 0 && hc < MAXW) halt_w[hc] = 1'b1;
        if (r2) begin
            x = $urandom_range(1, endc - 1);
            rv = $urandom();
            run_w[x] = 1'b1;
            lc_w[x] = rv[CW-1:0];
        end
        if (wr) begin
            x = $urandom_range(1, endc - 1);
            we_w[x] = 1'b1;
            we_dat = rnd_desc();
        end
        len = endc + 4;
    endtask

    task automatic play(input int len);
        for (int c = 0; c < len; c++) begin
            @(posedge clk); #1;
            wc = c;
            ack = ack_w[c]; run = run_w[c]; halt = halt_w[c];
            layer_count = lc_w[c]; desc_we = we_w[c];
            desc_addr = '0; desc_wdata = we_dat;
            chk_on = 1'b1;
        end
        @(posedge clk); #1;
        chk_on = 1'b0;
        ack = 1'b1; run = 1'b0; halt = 1'b0; desc_we = 1'b0;
        m_cur = e_cur[len-1];
        m_par = e_par[len-1];
        m_err = e_err[len-1];
    endtask

    task automatic scen(input int n, input int hc, input bit r2,
                        input bit wr, input bit ign);
        int len;
        build(n, hc, r2, wr, ign, len);
        play(len);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int r0;
        layer_desc_t d;
        we_dat = '0;
        repeat (3) @(posedge clk);
        #1 xrst = 1'b1;
        @(negedge clk);
        chk("rst_req", 128'(req), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_cur", 128'(cur_layer), 128'(0));
        chk("rst_par", 128'(got), 128'(0));

        for (int i = 0; i < 8; i++) begin
            d = rnd_desc();
            if (i < 3) d.img_size = LWIDTH'(12 - 2 * i);
            wr_desc(i, d);
        end

        // three layers, slow core
        for (int i = 0; i < 8; i++) begin f_a[i] = 1; h_a[i] = 50; end
        r0 = n_req;
        scen(3, -1, 1'b0, 1'b0, 1'b0);
        chk("three_reqs", 128'(n_req - r0), 128'(3));
        chk("three_busy", 128'(busy), 128'(0));
        chk("three_cur", 128'(cur_layer), 128'(2));
        chk("three_img", 128'(img_size), 128'(8));

        r0 = n_req;
        scen(0, -1, 1'b0, 1'b0, 1'b0);
        chk("zero_noreq", 128'(n_req - r0), 128'(0));

        // halt while layer 1 is in flight
        for (int i = 0; i < 8; i++) begin f_a[i] = 1; h_a[i] = 10; end
        r0 = n_req;
        scen(4, 20, 1'b0, 1'b0, 1'b0);
        chk("halt_reqs", 128'(n_req - r0), 128'(2));
        chk("halt_cur", 128'(cur_layer), 128'(1));

        f_a[0] = 9;
        scen(2, -1, 1'b0, 1'b0, 1'b0);
        chk("tmo_err", 128'(err), 128'(1));
        f_a[0] = 2;
        scen(1, -1, 1'b0, 1'b0, 1'b0);
        chk("err_clr", 128'(err), 128'(0));

        // dropped write to index 0 while busy, then rerun layer 0
        scen(2, -1, 1'b1, 1'b1, 1'b0);
        scen(1, -1, 1'b0, 1'b0, 1'b0);
        chk("drop_img", 128'(img_size), 128'(12));

        r0 = n_req;
        scen(2, -1, 1'b0, 1'b0, 1'b1);
        chk("ign_noreq", 128'(n_req - r0), 128'(0));

        // reset lands on the issue cycle
        r0 = n_req;
        @(posedge clk); #1 run = 1'b1; layer_count = CW'(2);
        @(posedge clk); #1 run = 1'b0;
        @(posedge clk); #1 xrst = 1'b0;
        @(negedge clk);
        chk("mid_rst_req", 128'(req), 128'(0));
        @(posedge clk); #1 xrst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_cur", 128'(cur_layer), 128'(0));
        chk("mid_rst_par", 128'(got), 128'(0));
        chk("mid_rst_err", 128'(err), 128'(0));
        repeat (4) @(negedge clk);
        chk("mid_rst_noreq", 128'(n_req - r0), 128'(0));
        m_cur = '0; m_par = '0; m_err = 1'b0;

        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 8; i++) begin
                f_a[i] = ($urandom_range(0, 9) == 0) ?
                         $urandom_range(5, 7) : $urandom_range(1, 4);
                h_a[i] = $urandom_range(1, 8);
            end
            if (k % 5 == 4) wr_desc($urandom_range(0, 7), rnd_desc());
            scen($urandom_range(0, 5),
                 ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 60),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
